// File: rtl/led_frame_builder.sv
// ---------------------------------------------------------------------------
// led_frame_builder
//   Collects per-channel brightness writes into a shadow buffer and, on a
//   commit or an auto-refresh tick, snapshots it into a stable frame for the
//   downstream spi_controller. Start is held until the controller reports the
//   transfer done. A timeout guards against a missing done.
//
//   Frame layout: o_frame_out[MSB -: 16] = HDR, then channel 0 .. CH_NUM-1,
//   each CH_W bits, channel 0 nearest the header (sent first, MSB-first).
//
// Ports
//   i_clk        system clock (same domain as spi_controller)
//   i_rst        asynchronous, active-high reset
//   i_wr_en      shadow-buffer write strobe
//   i_wr_addr    channel index; values >= CH_NUM are ignored
//   i_wr_data    channel value
//   i_commit     single-cycle request to send the shadow buffer
//   i_auto_en    enables periodic refresh
//   i_spi_done   done level from spi_controller
//   o_frame_out  {HDR, ch0, ch1, ...} to spi_controller data_in
//   o_start      start to spi_controller (high in SEND and WAIT)
//   o_busy       high in LOAD, SEND and WAIT
//   o_err        sticky timeout flag
//   o_frame_cnt  completed-frame counter (wraps)
// ---------------------------------------------------------------------------

// Per-channel lane: one shadow register plus its slice of the frame snapshot.
// The snapshot takes the write-first value so a write landing in the LOAD
// cycle is part of the frame being sent.
module led_fb_chan #(
  parameter int CH_W = 16,
  parameter int AW   = 5,
  parameter int IDX  = 0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_wr_en,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [CH_W-1:0] i_wr_data,
  input  logic            i_load,
  output logic [CH_W-1:0] o_frame
);

  logic            w_hit;
  logic [CH_W-1:0] w_next;
  logic [CH_W-1:0] r_shadow;
  logic [CH_W-1:0] r_frame;

  assign w_hit  = i_wr_en && (i_wr_addr == AW'(IDX));
  assign w_next = w_hit ? i_wr_data : r_shadow;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shadow <= '0;
    end else begin
      r_shadow <= w_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frame <= '0;
    end else if (i_load) begin
      r_frame <= w_next;
    end
  end

  assign o_frame = r_frame;

endmodule

module led_frame_builder #(
  parameter int          CH_NUM         = 24,
  parameter int          CH_W           = 16,
  parameter logic [15:0] HDR            = 16'hAA30,
  parameter int          REFRESH_CYCLES = 50000,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [4:0]               i_wr_addr,
  input  logic [CH_W-1:0]          i_wr_data,
  input  logic                     i_commit,
  input  logic                     i_auto_en,
  input  logic                     i_spi_done,
  output logic [16+CH_NUM*CH_W-1:0] o_frame_out,
  output logic                     o_start,
  output logic                     o_busy,
  output logic                     o_err,
  output logic [15:0]              o_frame_cnt
);

  localparam int FW = 16 + CH_NUM * CH_W;
  localparam int AW = 5;
  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [RW-1:0] REF_RELOAD = RW'(REFRESH_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic                          r_pending;
  logic [RW-1:0]                 r_ref_cnt;
  logic [TW-1:0]                 r_to_cnt;
  logic                          r_send_cnt;
  logic                          r_done_q;
  logic                          r_err;
  logic [15:0]                   r_frame_cnt;

  logic                          w_tick;
  logic                          w_go;
  logic                          w_rise;
  logic                          w_to_hit;
  logic                          w_xfer;
  logic                          w_load;
  logic                          w_frame_done;
  logic                          w_timeout;
  logic [CH_NUM-1:0][CH_W-1:0]   w_chan;

  // -------------------------------------------------------------------------
  // Channel lanes and frame assembly
  // -------------------------------------------------------------------------
  assign w_load = (r_state == S_LOAD);

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
    led_fb_chan #(
      .CH_W (CH_W),
      .AW   (AW),
      .IDX  (gi)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_wr_en   (i_wr_en),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_data),
      .i_load    (w_load),
      .o_frame   (w_chan[gi])
    );
    // Channel 0 sits directly below the header.
    assign o_frame_out[FW-17-CH_W*gi -: CH_W] = w_chan[gi];
  end

  assign o_frame_out[FW-1 -: 16] = HDR;

  // -------------------------------------------------------------------------
  // Request sources
  // -------------------------------------------------------------------------
  assign w_tick   = i_auto_en && (r_state == S_IDLE) && (r_ref_cnt == '0);
  // A commit seen in IDLE launches directly so commit -> start is 2 cycles;
  // commit, pending and tick together still yield a single frame.
  assign w_go     = r_pending || i_commit || w_tick;
  assign w_rise   = i_spi_done && !r_done_q;
  assign w_xfer   = (r_state == S_SEND) || (r_state == S_WAIT);
  assign w_to_hit = (r_to_cnt == TO_LAST);

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_frame_done = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (w_to_hit) begin
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end else if (!i_spi_done || r_send_cnt) begin
          // done low means accepted; after 2 cycles of high, assume accepted.
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A completion on the last allowed cycle still counts as a frame.
        if (w_rise) begin
          w_state_nxt  = S_IDLE;
          w_frame_done = 1'b1;
        end else if (w_to_hit) begin
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Pending commit, refresh timer, transfer counters, status
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending <= 1'b0;
    end else if ((r_state == S_IDLE) && w_go) begin
      r_pending <= 1'b0;
    end else if (i_commit) begin
      r_pending <= 1'b1;
    end
  end

  // Counts only in IDLE, so time spent busy pauses the refresh period.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ref_cnt <= REF_RELOAD;
    end else if (!i_auto_en) begin
      r_ref_cnt <= REF_RELOAD;
    end else if (r_state == S_IDLE) begin
      if (r_ref_cnt == '0) r_ref_cnt <= REF_RELOAD;
      else                 r_ref_cnt <= r_ref_cnt - RW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_to_cnt   <= '0;
      r_send_cnt <= 1'b0;
      r_done_q   <= 1'b0;
    end else begin
      r_to_cnt   <= w_xfer ? r_to_cnt + TW'(1) : '0;
      r_send_cnt <= (r_state == S_SEND);
      r_done_q   <= i_spi_done;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_timeout)    r_err       <= 1'b1;
      if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // Decoded from the state register so reset drops start asynchronously.
  assign o_start     = w_xfer;
  assign o_busy      = (r_state != S_IDLE);
  assign o_err       = r_err;
  assign o_frame_cnt = r_frame_cnt;

endmodule
